// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t : FSM state encoding (IDLE / RUN / DONE)
//   clog2   : constant function used to size the bit counter
package sumador_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest r such that 2**r >= value (value >= 2 gives r >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sumador_completo.sv
// Combinational 1-bit full adder.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sumador_serie.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles,
// LSB first, with a carry flip-flop between cycles.
//
// Handshake: start is sampled only in IDLE; at that edge a, b, cin and sub are
// captured and busy rises for exactly WIDTH cycles. done is then high for one
// cycle, and at the same edge sum/cout/overflow take the completed result.
// start in RUN or DONE is ignored (not queued).
//
// Ports:
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   start, sub : request, mode (0 = a+b+cin, 1 = a-b-cin)
//   a, b, cin  : operands and carry/borrow in
//   busy, done : RUN indicator, one-cycle result-valid pulse
//   sum, cout, overflow : result, raw MSB carry out, signed overflow
module sumador_serie
  import sumador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] part;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  sumador_completo u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      part     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            // Subtraction is a + ~b + ~cin, i.e. a - b - cin in two's complement.
            b_sr  <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          part  <= {fa_sum, part[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // MSB cycle: carry holds the carry into the MSB here.
            sum      <= {fa_sum, part[WIDTH-1:1]};
            cout     <= fa_cout;
            overflow <= carry ^ fa_cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serie.sv
// Bench for sumador_serie at WIDTH=8 and WIDTH=2. A cycle-level model of the
// handshake plus an arithmetic reference (integer sums, signed range test)
// predicts busy/done/sum/cout/overflow, which are compared every negedge.
module tb_sumador_serie;

  logic       clk;
  logic       rst_n;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2, sub2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  sumador_serie #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .overflow(ovf8)
  );

  sumador_serie #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
    .overflow(ovf2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: returns {overflow, cout, sum[31:0]}.
  function automatic logic [33:0] ref_op(input int w, input longint av,
                                         input longint bv, input bit c,
                                         input bit s);
    longint lim, half, as, bs, ru, rs;
    logic [33:0] r;
    lim  = longint'(1) << w;
    half = longint'(1) << (w - 1);
    as   = (av >= half) ? av - lim : av;
    bs   = (bv >= half) ? bv - lim : bv;
    r    = '0;
    if (s) begin
      ru    = av - bv - longint'(c);
      rs    = as - bs - longint'(c);
      r[32] = (ru >= 0);            // no borrow
    end else begin
      ru    = av + bv + longint'(c);
      rs    = as + bs + longint'(c);
      r[32] = (ru >= lim);
    end
    r[31:0] = 32'(ru & (lim - 1));
    r[33]   = (rs < -half) || (rs > half - 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: an accepted request keeps busy for WIDTH cycles, then done
  // for one cycle, with the result appearing together with done.
  int          m8_left = 0, m2_left = 0;
  bit          m8_done = 0, m2_done = 0;
  logic [33:0] m8_res = '0, m2_res = '0, m8_pend = '0, m2_pend = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m8_left = 0; m8_done = 0; m8_res = '0;
      m2_left = 0; m2_done = 0; m2_res = '0;
    end else begin
      if (m8_done) m8_done = 0;
      else if (m8_left > 0) begin
        m8_left--;
        if (m8_left == 0) begin m8_done = 1; m8_res = m8_pend; end
      end else if (start8) begin
        m8_pend = ref_op(8, a8, b8, cin8, sub8);
        m8_left = 8;
      end
      if (m2_done) m2_done = 0;
      else if (m2_left > 0) begin
        m2_left--;
        if (m2_left == 0) begin m2_done = 1; m2_res = m2_pend; end
      end else if (start2) begin
        m2_pend = ref_op(2, a2, b2, cin2, sub2);
        m2_left = 2;
      end
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", 64'(busy8), 64'(m8_left != 0));
      check("done8", 64'(done8), 64'(m8_done));
      check("sum8",  64'(sum8),  64'(m8_res[7:0]));
      check("cout8", 64'(cout8), 64'(m8_res[32]));
      check("ovf8",  64'(ovf8),  64'(m8_res[33]));
      check("busy2", 64'(busy2), 64'(m2_left != 0));
      check("done2", 64'(done2), 64'(m2_done));
      check("sum2",  64'(sum2),  64'(m2_res[1:0]));
      check("cout2", 64'(cout2), 64'(m2_res[32]));
      check("ovf2",  64'(ovf2),  64'(m2_res[33]));
    end
  end

  // driver: one WIDTH=8 operation with literal expectations
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v,
                     input bit tc, input bit ts, input logic [7:0] es,
                     input bit ec, input bit eo);
    int nb;
    bit got;
    nb  = 0;
    got = 0;
    @(negedge clk);
    a8 = ta; b8 = tb_v; cin8 = tc; sub8 = ts; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin got = 1; break; end
      if (busy8) nb++;
      @(negedge clk);
    end
    check("op8_done_seen", 64'(got), 64'(1));
    check("op8_busy_cycles", 64'(nb), 64'(8));
    check("op8_sum", 64'(sum8), 64'(es));
    check("op8_cout", 64'(cout8), 64'(ec));
    check("op8_ovf", 64'(ovf8), 64'(eo));
  endtask

  task automatic op2(input logic [1:0] ta, input logic [1:0] tb_v,
                     input bit tc, input bit ts);
    bit got;
    logic [33:0] e;
    got = 0;
    e   = ref_op(2, ta, tb_v, tc, ts);
    @(negedge clk);
    a2 = ta; b2 = tb_v; cin2 = tc; sub2 = ts; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done2) begin got = 1; break; end
      @(negedge clk);
    end
    check("op2_done_seen", 64'(got), 64'(1));
    check("op2_result", 64'({ovf2, cout2, sum2}), 64'({e[33], e[32], e[1:0]}));
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    start2 = 0; sub2 = 0; cin2 = 0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'(0));
    check("rst_done8", 64'(done8), 64'(0));
    check("rst_out8", 64'({ovf8, cout8, sum8}), 64'(0));
    check("rst_out2", 64'({busy2, done2, ovf2, cout2, sum2}), 64'(0));
    chk_en = 1;
    rst_n  = 1'b1;

    // pin the reference against hand-computed values
    check("ref_pin_add", 64'(ref_op(8, 'h7F, 'h00, 1, 0)), 64'({2'b10, 32'h80}));
    check("ref_pin_sub", 64'(ref_op(8, 'h80, 'h01, 0, 1)), 64'({2'b11, 32'h7F}));
    check("ref_pin_brw", 64'(ref_op(8, 'h05, 'h07, 0, 1)), 64'({2'b00, 32'hFE}));

    // basic add / carry / overflow
    op8('h0F, 'h01, 0, 0, 'h10, 0, 0);
    op8('hFF, 'h01, 0, 0, 'h00, 1, 0);
    op8('h7F, 'h00, 1, 0, 'h80, 0, 1);
    // subtract
    op8('h05, 'h07, 0, 1, 'hFE, 0, 0);
    op8('h80, 'h01, 0, 1, 'h7F, 1, 1);
    op8('h10, 'h00, 1, 1, 'h0F, 1, 0);

    // start held through RUN/DONE with changing operands
    @(negedge clk);
    a8 = 'h01; b8 = 'h01; cin8 = 0; sub8 = 0; start8 = 1'b1;
    @(negedge clk);
    a8 = 'hAA; b8 = 'h55;
    for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
    check("held_first_sum", 64'(sum8), 64'('h02));
    @(negedge clk);        // IDLE cycle: held start accepted at next edge
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
    check("held_second_sum", 64'(sum8), 64'('hFF));

    // reset in the 4th RUN cycle
    @(negedge clk);
    a8 = 'h3C; b8 = 'h3C; cin8 = 0; sub8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_state", 64'({busy8, done8, ovf8, cout8, sum8}), 64'(0));
    rst_n = 1'b1;
    op8('h3C, 'h3C, 0, 0, 'h78, 0, 0);

    // WIDTH=2 exhaustive sweep
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++)
            op2(2'(ia), 2'(ib), 1'(ic), 1'(is));

    // random traffic with occasional resets on the WIDTH=8 instance
    repeat (3000) begin
      @(negedge clk);
      rst_n  = ($urandom_range(0, 299) != 0);
      start8 = ($urandom_range(0, 3) == 0);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      cin8   = 1'($urandom_range(0, 1));
      sub8   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst_n  = 1'b1;
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
